sram_access_ctrl: RTL

//  Timed access sequencer between a processor-side request port and the async sram block.

---
 rtl/sram_access_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: timed access sequencer between a one-cycle req/ready processor port and an
// asynchronous SRAM. Each accepted request becomes an SRAM cycle made of three phases:
// address/direction setup, enable strobe and hold.
//
// Ports:
//   CLOCK_50   in     system clock, rising edge
//   reset_n    in     asynchronous active-low reset
//   req        in     request, accepted on an edge where req & ready
//   we         in     1 = write, 0 = read (sampled with req)
//   addr       in     word address (sampled with req)
//   wdata      in     write data (sampled with req)
//   ready      out    idle, able to accept a request
//   rdata      out    read data, updated when rvalid pulses
//   rvalid     out    one-cycle pulse on read completion
//   sram_addr  out    SRAM address
//   sram_rw    out    1 = read, 0 = write
//   sram_en    out    SRAM enable, active high
//   sram_data  inout  SRAM data bus, driven only for the duration of a write transaction
module sram_access_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rw,
    output logic              sram_en,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int unsigned MaxSa    = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int unsigned MaxPhase = (MaxSa > HOLD_CYC) ? MaxSa : HOLD_CYC;
    localparam int unsigned CntW     = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;

    // Counter is loaded with length-1 on phase entry; the phase ends on the cycle it reads 0.
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] AccessLoad = CntW'(ACCESS_CYC - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              en_q, en_d;
    logic              drive_q, drive_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b1;
            en_q     <= 1'b0;
            drive_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            drive_q  <= drive_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        en_d     = en_q;
        drive_d  = drive_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req && ready_q) begin
                    addr_d  = addr;
                    rw_d    = ~we;
                    drive_d = we;
                    wdata_d = wdata;
                    ready_d = 1'b0;
                    cnt_d   = SetupLoad;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = AccessLoad;
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                    // Sample on the edge that closes the strobe; the SRAM output is settled.
                    if (rw_q) begin
                        rdata_d  = sram_data;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    drive_d = 1'b0;
                    rw_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready     = ready_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_rw   = rw_q;
    assign sram_en   = en_q;
    assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
